state_sequence_ctrl: RTL and testbench
======================================

Name: state_sequence_ctrl

Overview:
Run controller for the 2-bit state machine (iPause / restart / oValorEstado interface). It holds the machine in restart while idle. Once started, it keeps the machine's pause input asserted and releases it for exactly one cycle each time the current state's programmable dwell time expires, so each state lasts a configured number of cycles. It also supports operator pause, single-step and stop, counts completed 0→1→2→3→0 laps, and flags any mismatch between the machine's reported state and the expected sequence.

Parameters:
CNT_W, 8, dwell counter width
DWELL0, 5, cycles spent in machine state 0 (legal 1..2^CNT_W-1)
DWELL1, 3, cycles in state 1
DWELL2, 5, cycles in state 2
DWELL3, 2, cycles in state 3
LAP_W, 4, lap counter width

Ports:
iClk  in  1  clock, all logic on rising edge
iRestart  in  1  asynchronous reset, active-low
iStart  in  1  level; begin a run from IDLE
iStop  in  1  level; abort to IDLE from any state
iPause  in  1  level; operator pause request
iStep  in  1  level; single advance while PAUSED
iValorEstado  in  2  current state reported by the controlled machine
oRestart  out  1  active-high restart to the machine; =1 iff ctrl state is IDLE
oPause  out  1  pause to the machine; 0 only in an advance cycle
oEstadoCtrl  out  2  controller state: IDLE=00, RUN=01, PAUSED=10, STEP=11
oVueltas  out  LAP_W  completed laps, wraps modulo 2^LAP_W
oError  out  1  sticky sequence-mismatch flag

Behaviour:
- Reset (iRestart=0, async):
  - ctrl state IDLE, oRestart=1, oPause=1, oEstadoCtrl=00.
  - Dwell counter cnt=0, expected state exp=0, oVueltas=0, oError=0.
- Advance cycle: oAdvance (internal) = (state==RUN && cnt==0 && !iPause && !iStop) || state==STEP. oPause = ~oAdvance (combinational from regs + iPause/iStop).
- On an advance edge:
  - exp <= exp+1 (mod 4).
  - cnt <= DWELL[exp+1]-1.
  - If exp==3: oVueltas <= oVueltas+1.
  - Machine state k is therefore held exactly DWELLk cycles; DWELL=1 gives an advance every cycle.
- Transitions (priority iStop > iPause > iStep/iStart):
  - IDLE: iStart=1 → RUN. Same edge: cnt <= DWELL0-1, exp <= 0, oVueltas <= 0, oError <= 0.
  - RUN: iStop → IDLE. Else iPause → PAUSED, cnt frozen, no advance that cycle. Else cnt decrements when cnt!=0; advance when cnt==0.
  - PAUSED: iStop → IDLE. Else iPause=0 → RUN with cnt unchanged. Else iStep=1 → STEP.
  - STEP: one cycle with advance performed, then → PAUSED unconditionally. iStop during STEP → IDLE, but the advance still occurs that cycle. A held iStep yields one step per STEP→PAUSED→STEP round (every 2 cycles).
- Error check: every cycle with state!=IDLE, if iValorEstado!=exp then oError <= 1. oError is sticky until the next iStart or reset.
- Return to IDLE (iStop): oRestart=1 the next cycle. cnt, exp and oVueltas are retained for readback until the next iStart.
- iStart while not IDLE: ignored. iStep outside PAUSED: ignored.
- Reset mid-run: immediate IDLE and all values at reset.

Test Plan:
- Reset then idle: iRestart=0 for 2 cycles, then 1 with no inputs → oRestart=1, oPause=1, oEstadoCtrl=00, oVueltas=0, oError=0; machine stays at 0.
- Nominal timing: iStart for 1 cycle with defaults → oPause low in RUN cycles 5, 8, 13, 15. iValorEstado sequence 0(×5),1(×3),2(×5),3(×2). oVueltas=1 after 15 RUN cycles, 3 after 45. oError=0.
- Pause/resume: iPause=1 during RUN cycle 3 for 10 cycles → oEstadoCtrl=10, oPause=1 throughout. After release, first advance comes 3 cycles later (cnt resumed at 2).
- Single step: paused in state 1, iStep=1 for one cycle → oEstadoCtrl 10→11→10, exactly one oPause-low cycle. iValorEstado 1→2, cnt reloaded to 4.
- Mismatch: force iValorEstado=3 while exp=1 → oError=1 next edge and stays 1 after correction. Cleared by iStop then iStart.
- Stop/priority: iStop and iPause together in RUN → IDLE, oRestart=1 next cycle. iStart while RUN has no effect. Async reset mid-run clears oVueltas to 0 immediately.

Source files
------------

// File: rtl/state_sequence_ctrl.sv
// Run controller for a 2-bit state machine: holds it in restart while idle, then
// releases its pause for one cycle whenever the current state's dwell time expires.
module state_sequence_ctrl #(
   parameter int CNT_W  = 8,
   parameter int DWELL0 = 5,
   parameter int DWELL1 = 3,
   parameter int DWELL2 = 5,
   parameter int DWELL3 = 2,
   parameter int LAP_W  = 4
) (
   input  logic             iClk,
   input  logic             iRestart,
   input  logic             iStart,
   input  logic             iStop,
   input  logic             iPause,
   input  logic             iStep,
   input  logic [1:0]       iValorEstado,
   output logic             oRestart,
   output logic             oPause,
   output logic [1:0]       oEstadoCtrl,
   output logic [LAP_W-1:0] oVueltas,
   output logic             oError
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      STEP   = 2'b11
   } ctrlState_t;

   ctrlState_t       state, stateNext;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       expEstado;
   logic [1:0]       expNext;
   logic [LAP_W-1:0] vueltas;
   logic             error;
   logic             advance;

   // Counter reload so that machine state k is held for exactly DWELLk cycles.
   function automatic logic [CNT_W-1:0] dwellReload(input logic [1:0] k);
      logic [CNT_W-1:0] r;
      case (k)
         2'd0:    r = CNT_W'(DWELL0 - 1);
         2'd1:    r = CNT_W'(DWELL1 - 1);
         2'd2:    r = CNT_W'(DWELL2 - 1);
         default: r = CNT_W'(DWELL3 - 1);
      endcase
      return r;
   endfunction

   assign expNext = expEstado + 2'd1;

   always_comb begin
      advance   = 1'b0;
      stateNext = state;
      case (state)
         IDLE: begin
            if (iStart) stateNext = RUN;
         end
         RUN: begin
            if (iStop)       stateNext = IDLE;
            else if (iPause) stateNext = PAUSED;
            else if (cnt == '0) advance = 1'b1;
         end
         PAUSED: begin
            if (iStop)        stateNext = IDLE;
            else if (!iPause) stateNext = RUN;
            else if (iStep)   stateNext = STEP;
         end
         STEP: begin
            // The step advance happens even when a stop arrives in the same cycle.
            advance   = 1'b1;
            stateNext = iStop ? IDLE : PAUSED;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRestart) begin
      if (!iRestart) state <= IDLE;
      else           state <= stateNext;
   end

   always_ff @(posedge iClk or negedge iRestart) begin
      if (!iRestart) begin
         cnt       <= '0;
         expEstado <= 2'd0;
         vueltas   <= '0;
         error     <= 1'b0;
      end else if (state == IDLE) begin
         // Values from the previous run stay readable until the next start.
         if (iStart) begin
            cnt       <= dwellReload(2'd0);
            expEstado <= 2'd0;
            vueltas   <= '0;
            error     <= 1'b0;
         end
      end else begin
         if (iValorEstado != expEstado) error <= 1'b1;
         if (advance) begin
            expEstado <= expNext;
            cnt       <= dwellReload(expNext);
            if (expEstado == 2'd3) vueltas <= vueltas + 1'b1;
         end else if (state == RUN && !iStop && !iPause && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign oRestart    = (state == IDLE);
   assign oPause      = ~advance;
   assign oEstadoCtrl = state;
   assign oVueltas    = vueltas;
   assign oError      = error;

endmodule

// File: tb/tb_state_sequence_ctrl.sv
// Directed bench for state_sequence_ctrl driving a simple 2-bit counting machine
// that steps on every cycle its pause input is low.
module tb_state_sequence_ctrl;

   logic       iClk = 1'b0;
   logic       iRestart, iStart, iStop, iPause, iStep;
   logic [1:0] iValorEstado;
   logic       oRestart, oPause, oError;
   logic [1:0] oEstadoCtrl;
   logic [3:0] oVueltas;
   logic [1:0] mach;
   logic       forceBad;
   int         nAsserts = 0;
   int         nFails = 0;

   state_sequence_ctrl dut (
      .iClk(iClk), .iRestart(iRestart), .iStart(iStart), .iStop(iStop),
      .iPause(iPause), .iStep(iStep), .iValorEstado(iValorEstado),
      .oRestart(oRestart), .oPause(oPause), .oEstadoCtrl(oEstadoCtrl),
      .oVueltas(oVueltas), .oError(oError)
   );

   always #5 iClk = ~iClk;

   // Controlled machine: cleared by restart, increments when unpaused.
   always @(posedge iClk or negedge iRestart) begin
      if (!iRestart)     mach <= 2'd0;
      else if (oRestart) mach <= 2'd0;
      else if (!oPause)  mach <= mach + 2'd1;
   end
   assign iValorEstado = forceBad ? 2'd3 : mach;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nAsserts++;
      assert (obs === expv) else begin
         nFails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   function automatic int expValor(input int c);
      int p;
      p = (c - 1) % 15;
      if (p < 5)       return 0;
      else if (p < 8)  return 1;
      else if (p < 13) return 2;
      else             return 3;
   endfunction

   function automatic int expPause(input int c);
      int p;
      p = c % 15;
      return (p == 5 || p == 8 || p == 13 || p == 0) ? 0 : 1;
   endfunction

   initial begin
      iRestart = 1'b0; iStart = 1'b0; iStop = 1'b0; iPause = 1'b0; iStep = 1'b0;
      forceBad = 1'b0;

      // Reset and idle
      tick(); tick();
      chk("rst_restart", oRestart, 1);
      chk("rst_pause", oPause, 1);
      chk("rst_state", oEstadoCtrl, 0);
      chk("rst_laps", oVueltas, 0);
      chk("rst_err", oError, 0);
      iRestart = 1'b1;
      tick(); tick();
      chk("idle_restart", oRestart, 1);
      chk("idle_pause", oPause, 1);
      chk("idle_state", oEstadoCtrl, 0);
      chk("idle_mach", iValorEstado, 0);

      // Nominal timing over three laps
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      #1;
      for (int c = 1; c <= 45; c++) begin
         chk("nom_state", oEstadoCtrl, 1);
         chk("nom_pause", oPause, expPause(c));
         chk("nom_valor", iValorEstado, expValor(c));
         chk("nom_laps", oVueltas, (c - 1) / 15);
         tick();
      end
      chk("nom_laps3", oVueltas, 3);
      chk("nom_err", oError, 0);

      // Pause in lap cycle 3 for 10 cycles (cnt frozen at 2)
      tick(); tick();
      iPause = 1'b1;
      #1;
      chk("pz_blocked", oPause, 1);
      tick();
      for (int i = 0; i < 9; i++) begin
         chk("pz_state", oEstadoCtrl, 2);
         chk("pz_pause", oPause, 1);
         tick();
      end
      iPause = 1'b0;
      #1;
      chk("pz_release", oPause, 1);
      tick();
      chk("rs_state", oEstadoCtrl, 1);
      chk("rs_p1", oPause, 1);
      tick();
      chk("rs_p2", oPause, 1);
      tick();
      chk("rs_p3", oPause, 0);
      chk("rs_valor", iValorEstado, 0);
      tick();
      chk("rs_valor1", iValorEstado, 1);

      // Single step from state 1
      iPause = 1'b1;
      tick();
      chk("st_paused", oEstadoCtrl, 2);
      iStep = 1'b1;
      #1;
      chk("st_pre_pause", oPause, 1);
      tick();
      iStep = 1'b0;
      #1;
      chk("st_state", oEstadoCtrl, 3);
      chk("st_pause", oPause, 0);
      chk("st_valor_pre", iValorEstado, 1);
      tick();
      chk("st_back", oEstadoCtrl, 2);
      chk("st_pause_after", oPause, 1);
      chk("st_valor_post", iValorEstado, 2);
      iPause = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("st_reload", oPause, (i == 4) ? 0 : 1);
         tick();
      end
      chk("st_valor3", iValorEstado, 3);

      // Stop together with pause while running
      iStop = 1'b1; iPause = 1'b1;
      #1;
      chk("sp_pause", oPause, 1);
      tick();
      iStop = 1'b0; iPause = 1'b0;
      #1;
      chk("sp_state", oEstadoCtrl, 0);
      chk("sp_restart", oRestart, 1);
      chk("sp_laps_kept", oVueltas, 3);
      tick();
      chk("sp_mach", iValorEstado, 0);

      // Restart with iStart held: extra starts are ignored
      iStart = 1'b1;
      tick();
      chk("rs2_laps", oVueltas, 0);
      for (int i = 0; i < 5; i++) begin
         chk("ign_start", oPause, (i == 4) ? 0 : 1);
         tick();
      end
      iStart = 1'b0;

      // Sequence mismatch while exp=1
      forceBad = 1'b1;
      #1;
      chk("mm_before", oError, 0);
      tick();
      chk("mm_set", oError, 1);
      forceBad = 1'b0;
      tick();
      chk("mm_sticky", oError, 1);
      iStop = 1'b1;
      tick();
      iStop = 1'b0;
      chk("mm_idle_kept", oError, 1);
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      chk("mm_cleared", oError, 0);
      tick();
      chk("mm_clean_run", oError, 0);

      // Async reset mid-run after one lap
      for (int i = 0; i < 14; i++) tick();
      chk("ar_laps1", oVueltas, 1);
      #2;
      iRestart = 1'b0;
      #1;
      chk("ar_laps0", oVueltas, 0);
      chk("ar_state", oEstadoCtrl, 0);
      chk("ar_restart", oRestart, 1);
      tick();
      iRestart = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
